scan_ctrl: RTL and testbench
============================

# scan_ctrl

Scan test sequencer that drives the serial scan port of a scan-enabled datapath block, such as the 4-bit ALU with its result-register scan chain. On each `start` it shifts a parallel test pattern into the chain, issues one functional capture cycle, and shifts the captured response back out. It then compares the response against an expected vector and reports pass/fail. It sits between the test access logic (upstream) and the chain under test (downstream), and consumes that chain's `scan_out`.

## Interface
- `CHAIN_LEN`, default 4: number of flops in the chain under test (≥1).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a test; sampled only in IDLE.
- `pattern`  in  CHAIN_LEN  stimulus vector, latched on accepted `start`.
- `expected`  in  CHAIN_LEN  expected response, latched on accepted `start`.
- `chain_so`  in  1  `scan_out` of the chain under test.
- `scan_en`  out  1  to the chain `scan_en`; registered.
- `scan_si`  out  1  to the chain `scan_in`; registered.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is high.
- `done`  out  1  one-cycle pulse, test complete.
- `pass`  out  1  `captured == expected`; valid with `done`, held until the next accepted `start`.
- `captured`  out  CHAIN_LEN  response shifted out; valid with `done`, held.

## Operation
- Reset values: `scan_en` 0, `scan_si` 0, `busy` 0, `done` 0, `pass` 0, `captured` 0, state IDLE, bit counter 0.
- States:
  - IDLE → SHIFT_IN on `start`.
  - SHIFT_IN → CAPTURE after CHAIN_LEN bits.
  - CAPTURE → SHIFT_OUT after 1 cycle.
  - SHIFT_OUT → DONE after CHAIN_LEN samples.
  - DONE → IDLE after 1 cycle.
- Shift order, in: MSB first. `pattern[CHAIN_LEN-1]` is the first bit driven, so after CHAIN_LEN shifts the chain's first flop holds `pattern[0]`.
- Shift order, out: the first bit sampled from `chain_so` becomes `captured[CHAIN_LEN-1]`. The bit sampled last becomes `captured[0]`.
- In SHIFT_OUT, `scan_si` is driven 0, which flushes the chain.
- `start` outside IDLE is ignored. There is no queueing.
- A reset assertion at any point aborts the test immediately. All outputs return to reset values and no `done` is issued.
- The bit counter is $clog2(CHAIN_LEN+1) bits wide. It reloads to 0 on each state entry and never wraps within a phase.

## Timing
Edge 0 is the edge that samples `start` high in IDLE; N = CHAIN_LEN.
- Edge 0: latch `pattern` and `expected`; `scan_en`←1, `scan_si`←`pattern[N-1]`, `busy`←1.
- Edges 1..N-1: `scan_si`←next lower bit. The chain shifts on edges 1..N.
- Edge N: `scan_en`←0 (CAPTURE).
- Edge N+1: the chain captures its functional value; `scan_en`←1, `scan_si`←0 (SHIFT_OUT).
- Edges N+2..2N+1: sample `chain_so`, one bit per edge. The pre-edge value is the sampled bit.
- Edge 2N+1: `scan_en`←0.
- Edge 2N+2: `done`←1, `busy`←0, `pass` and `captured` updated.
- Edge 2N+3: `done`←0. A `start` sampled at this edge is accepted (back-to-back allowed).
- Start-to-done latency is 2N+2 cycles; for N=4, `done` is high after edge 10.

## Structure
- Package `scan_ctrl_pkg`:
  - state encoding localparams (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE);
  - default CHAIN_LEN;
  - counter width function.
- Sub-module `scan_shreg`: a parameterized CHAIN_LEN shift register with parallel load, serial in/out and shift enable. It is instantiated twice, once as the pattern serializer and once as the response deserializer.
- The FSM and the bit counter stay in `scan_ctrl`.

## Test plan
- Bench models a 4-flop chain that captures the constant 0101. `pattern`=1011, `expected`=0101 → `scan_si` is 1,0,1,1 on cycles 1–4; `scan_en` is low only during cycle 5; `done` after edge 10 with `pass`=1 and `captured`=0101.
- Same setup with `expected`=0110 → `pass`=0, `captured`=0101.
- Bench chain in pure-shift mode (capture holds its contents) with `pattern`=1011 → `captured`=1011 and `pass`=1 when `expected`=1011.
- `start` pulsed at cycles 3 and 7 during a test → ignored; exactly one `done`, at the original time.
- `rst` low at cycle 3 of SHIFT_IN → all outputs are 0 immediately; no `done`; a fresh `start` after release completes normally.
- `start` held high continuously → `done` every 11 cycles (N=4), with `pass` updated each time.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan test sequencer: FSM state codes,
// default chain length and the bit-counter width rule.
package scan_ctrl_pkg;

  localparam int DEFAULT_CHAIN_LEN = 4;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_SHIFT_IN  = 3'd1;
  localparam logic [STATE_W-1:0] S_CAPTURE   = 3'd2;
  localparam logic [STATE_W-1:0] S_SHIFT_OUT = 3'd3;
  localparam logic [STATE_W-1:0] S_DONE      = 3'd4;

  // The counter must be able to represent CHAIN_LEN itself.
  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/scan_shreg.sv
// Left-shifting register with parallel load and serial input; the MSB is
// the serial output end. Load takes priority over shift.
module scan_shreg
  import scan_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_CHAIN_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             si,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shifted;

  generate
    if (WIDTH == 1) begin : g_single
      assign shifted = si;
    end else begin : g_multi
      assign shifted = {q[WIDTH-2:0], si};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/scan_ctrl.sv
// Scan test sequencer: shifts a pattern into a scan chain MSB first, runs one
// capture cycle, shifts the response out and compares it with the expected vector.
module scan_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic                 chain_so,
  output logic                 scan_en,
  output logic                 scan_si,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] captured
);

  localparam int CW = cnt_width(CHAIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  logic [STATE_W-1:0]   state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [CHAIN_LEN-1:0] expected_reg;
  logic [CHAIN_LEN-1:0] ser_q;
  logic [CHAIN_LEN-1:0] resp_q;
  logic                 ser_q_unused;

  logic accept, ser_shift, des_shift, result_load;
  logic scan_en_next, busy_next, done_next;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      scan_en      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      captured     <= '0;
      expected_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      scan_en   <= scan_en_next;
      busy      <= busy_next;
      done      <= done_next;
      if (accept) begin
        expected_reg <= expected;
      end
      if (result_load) begin
        captured <= resp_q;
        pass     <= (resp_q == expected_reg);
      end
    end
  end

  // Next state; the counter restarts at zero on every state entry.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (start) state_next = S_SHIFT_IN;
      S_SHIFT_IN:  if (cnt_reg == LAST) state_next = S_CAPTURE;
      S_CAPTURE:   state_next = S_SHIFT_OUT;
      S_SHIFT_OUT: if (cnt_reg == LAST) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase

    cnt_next = cnt_reg;
    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if (state_reg == S_SHIFT_IN || state_reg == S_SHIFT_OUT) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    accept       = (state_reg == S_IDLE) && start;
    ser_shift    = (state_reg == S_SHIFT_IN);
    des_shift    = (state_reg == S_SHIFT_OUT);
    result_load  = (state_reg == S_DONE);
    scan_en_next = (state_next == S_SHIFT_IN) || (state_next == S_SHIFT_OUT);
    busy_next    = (state_next != S_IDLE);
    done_next    = (state_reg == S_DONE);
  end

  // Zero fill empties the serializer during SHIFT_IN, so scan_si is 0 from CAPTURE on.
  scan_shreg #(.WIDTH(CHAIN_LEN)) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (pattern),
    .shift    (ser_shift),
    .si       (1'b0),
    .q        (ser_q)
  );

  scan_shreg #(.WIDTH(CHAIN_LEN)) u_deserializer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val ('0),
    .shift    (des_shift),
    .si       (chain_so),
    .q        (resp_q)
  );

  assign scan_si      = ser_q[CHAIN_LEN-1];
  assign ser_q_unused = ^ser_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Self-checking bench for scan_ctrl: models a 4-flop scan chain (constant
// capture or pure-shift) and predicts every response from the pattern rules.
module tb_scan_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] pattern = '0;
  logic [N-1:0] expected = '0;
  logic         chain_so;
  logic         scan_en, scan_si, busy, done, pass;
  logic [N-1:0] captured;

  // Chain model: chain[0] is the first flop, chain[N-1] drives scan_out.
  logic [N-1:0] chain = '0;
  logic         cap_mode = 1'b1;
  logic [N-1:0] cap_val = '0;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int done_count = 0;
  int done_cyc = 0;

  scan_ctrl #(.CHAIN_LEN(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
    .expected (expected),
    .chain_so (chain_so),
    .scan_en  (scan_en),
    .scan_si  (scan_si),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .captured (captured)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (scan_en) chain <= {chain[N-2:0], scan_si};
    else if (cap_mode) chain <= cap_val;
  end
  assign chain_so = chain[N-1];

  always @(negedge clk) begin
    if (rst && done) begin
      done_count <= done_count + 1;
      done_cyc   <= cyc;
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({scan_en, scan_si, busy, done, pass} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: en/si/busy/done/pass=%b required 00000", {scan_en, scan_si, busy, done, pass});
    end
    tests_run++;
    if (captured !== '0) begin
      tests_failed++;
      $display("FAIL reset_captured: got %b required 0000", captured);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || scan_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: busy=%b scan_en=%b required 0 0", busy, scan_en);
    end
  endtask

  // One full test with per-cycle timing checks against the edge schedule.
  task automatic test_scan_sequence(input logic [N-1:0] pat, input logic [N-1:0] exp_v,
                                    input logic mode, input logic [N-1:0] cv, input string name);
    logic [N-1:0] model_cap;
    logic model_pass;
    logic exp_en, exp_busy, exp_done;
    model_cap  = mode ? cv : pat;
    model_pass = (model_cap == exp_v);
    cap_mode = mode;
    cap_val  = cv;
    pattern  = pat;
    expected = exp_v;
    start    = 1'b1;
    for (int k = 0; k <= 2*N+3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        pattern = N'($urandom);
        expected = N'($urandom);
      end
      exp_en   = (k < N) || (k > N && k <= 2*N);
      exp_busy = (k <= 2*N+1);
      exp_done = (k == 2*N+2);
      tests_run++;
      if (scan_en !== exp_en) begin
        tests_failed++;
        $display("FAIL %s scan_en k=%0d: got %b required %b", name, k, scan_en, exp_en);
      end
      tests_run++;
      if (busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL %s busy k=%0d: got %b required %b", name, k, busy, exp_busy);
      end
      tests_run++;
      if (done !== exp_done) begin
        tests_failed++;
        $display("FAIL %s done k=%0d: got %b required %b", name, k, done, exp_done);
      end
      if (k < N) begin
        tests_run++;
        if (scan_si !== pat[N-1-k]) begin
          tests_failed++;
          $display("FAIL %s scan_si k=%0d: got %b required %b", name, k, scan_si, pat[N-1-k]);
        end
      end else if (k > N && k <= 2*N) begin
        tests_run++;
        if (scan_si !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s scan_si_flush k=%0d: got %b required 0", name, k, scan_si);
        end
      end
      if (k >= 2*N+2) begin
        tests_run++;
        if (captured !== model_cap) begin
          tests_failed++;
          $display("FAIL %s captured k=%0d: got %b required %b", name, k, captured, model_cap);
        end
        tests_run++;
        if (pass !== model_pass) begin
          tests_failed++;
          $display("FAIL %s pass k=%0d: got %b required %b", name, k, pass, model_pass);
        end
      end
    end
    $display("[TB] %s pattern=%b expected=%b captured=%b pass=%b", name, pat, exp_v, captured, pass);
  endtask

  task automatic test_random();
    logic [N-1:0] pat, cv, exp_v;
    logic mode;
    for (int i = 0; i < 8; i++) begin
      pat  = N'($urandom);
      cv   = N'($urandom);
      mode = 1'($urandom);
      exp_v = ($urandom_range(0, 1) == 1) ? (mode ? cv : pat) : N'($urandom);
      test_scan_sequence(pat, exp_v, mode, cv, "random");
    end
  endtask

  task automatic test_ignore_start();
    logic [N-1:0] pat, cv;
    int c0, d0;
    pat = N'($urandom);
    cv  = N'($urandom);
    cap_mode = 1'b1;
    cap_val  = cv;
    pattern  = pat;
    expected = cv;
    c0 = cyc;
    d0 = done_count;
    start = 1'b1;
    for (int k = 0; k <= 2*(2*N+3)+2; k++) begin
      @(negedge clk);
      start = (k == 2 || k == 6);
      if (k == 0) pattern = ~pat;
      if (k == 2*N+2) begin
        tests_run++;
        if (done !== 1'b1 || captured !== cv) begin
          tests_failed++;
          $display("FAIL ignore_start_result: done=%b captured=%b required 1 %b", done, captured, cv);
        end
      end
    end
    start = 1'b0;
    tests_run++;
    if (done_count - d0 != 1) begin
      tests_failed++;
      $display("FAIL ignore_start_count: got %0d done pulses required 1", done_count - d0);
    end
    tests_run++;
    if (done_cyc != c0 + 2*N+3) begin
      tests_failed++;
      $display("FAIL ignore_start_time: done at cycle %0d required %0d", done_cyc, c0 + 2*N+3);
    end
    $display("[TB] ignore_start pattern=%b done_pulses=%0d", pat, done_count - d0);
  endtask

  task automatic test_reset_abort();
    logic [N-1:0] pat;
    int d0;
    pat = N'($urandom);
    cap_mode = 1'b1;
    cap_val  = N'($urandom);
    pattern  = pat;
    expected = cap_val;
    start = 1'b1;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({scan_en, scan_si, busy, done, pass} !== 5'b0 || captured !== '0) begin
      tests_failed++;
      $display("FAIL abort_outputs: en/si/busy/done/pass=%b captured=%b required all 0",
               {scan_en, scan_si, busy, done, pass}, captured);
    end
    d0 = done_count;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2*N+6) @(negedge clk);
    tests_run++;
    if (done_count != d0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_done: done pulses=%0d busy=%b required 0 0", done_count - d0, busy);
    end
    $display("[TB] reset_abort pattern=%b done_pulses=%0d", pat, done_count - d0);
    test_scan_sequence(N'($urandom), 4'b0101, 1'b1, 4'b0101, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] p [3];
    logic [N-1:0] e [3];
    int d0;
    for (int j = 0; j < 3; j++) begin
      p[j] = N'($urandom);
      e[j] = ($urandom_range(0, 1) == 1) ? p[j] : N'($urandom);
    end
    cap_mode = 1'b0;
    d0 = done_count;
    pattern  = p[0];
    expected = e[0];
    start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k <= 2*N+2; k++) begin
        @(negedge clk);
        if (k == 0) begin
          pattern  = N'($urandom);
          expected = N'($urandom);
        end
        tests_run++;
        if (done !== (k == 2*N+2)) begin
          tests_failed++;
          $display("FAIL b2b_done test=%0d k=%0d: got %b required %b", j, k, done, (k == 2*N+2));
        end
        if (k == 2*N+2) begin
          tests_run++;
          if (captured !== p[j] || pass !== (p[j] == e[j])) begin
            tests_failed++;
            $display("FAIL b2b_result test=%0d: captured=%b pass=%b required %b %b",
                     j, captured, pass, p[j], (p[j] == e[j]));
          end
          $display("[TB] back_to_back test=%0d pattern=%b expected=%b captured=%b pass=%b",
                   j, p[j], e[j], captured, pass);
          if (j < 2) begin
            pattern  = p[j+1];
            expected = e[j+1];
          end else begin
            start = 1'b0;
          end
        end
      end
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (done_count - d0 != 3 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_count: done pulses=%0d busy=%b required 3 0", done_count - d0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_scan_sequence(4'b1011, 4'b0101, 1'b1, 4'b0101, "capture_pass");
    test_scan_sequence(4'b1011, 4'b0110, 1'b1, 4'b0101, "capture_mismatch");
    test_scan_sequence(4'b1011, 4'b1011, 1'b0, 4'b0000, "pure_shift");
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
